instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Front-end stage sitting directly upstream of merge_execution.
- Fetches 16-bit instructions from IMEM over a req/ack handshake and holds them in an instruction register.
- Decodes each instruction into func/register-address/immediate fields for the register file and execution unit.
- Advances the PC only when the downstream stage accepts the instruction, and halts on an invalid opcode.

Parameters:
- ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, width of the IMEM word address and PC.
- INSTR_WIDTH, 16, instruction word width; the field map below is fixed for 16.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, fetch-wait limit; used only with IFETCH_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset; synchronous, active-low (Already decided)
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_WIDTH  word address of the fetch; equals PC
- imem_rdata_i  in  INSTR_WIDTH  fetched instruction
- imem_ack_i  in  1  fetch complete; rdata valid in the same cycle
- ex_ready_i  in  1  execution stage accepts the issued instruction; low while a LOAD/STORE waits on dmem_ack_i
- valid_o  out  1  decoded fields are valid
- func_o  out  4  opcode as func_t: AND=0 OR=1 XOR=2 NOT=3 ADDI=4 ADD=5 SUB=6 SLL=7 SLLI=8 SLR=9 SLRI=10 LOAD=11 STORE=12
- rd_addr_o  out  3  destination register
- rs1_addr_o  out  3  source register 1
- rs2_addr_o  out  3  source register 2
- imm_o  out  6  raw immediate; execution stage sign-extends it
- rd_we_o  out  1  register write enable: 1 for func 0-11, 0 for STORE
- pc_o  out  ADDR_WIDTH  PC of the issued instruction
- halt_o  out  1  sticky halt flag

Behaviour:
- Instruction format:
  - [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm.
  - rs2 and imm overlap; both are always driven from the instruction register.
- Reset (arst_ni low at a posedge):
  - Takes priority over every other event.
  - State=FETCH; pc=RESET_PC; IR cleared.
  - imem_req_o=0, valid_o=0, halt_o=0, rd_we_o=0.
  - func_o, rd_addr_o, rs1_addr_o, rs2_addr_o and imm_o = 0; imem_addr_o=pc_o=RESET_PC.
  - A fetch pending when reset hits is abandoned; an ack arriving in the reset cycle is ignored.
- imem_req_o is combinational from state: 1 only in FETCH while arst_ni was high on the previous edge. It is 0 in the first cycle after reset release and rises in the cycle after that.
- FETCH:
  - imem_req_o=1 and imem_addr_o=pc, both held stable until ack.
  - On a posedge with imem_ack_i=1: IR<=imem_rdata_i.
    - Opcode 0-12: go ISSUE.
    - Opcode 13-15 (INVALID): go HALT.
  - imem_ack_i while imem_req_o=0 is ignored.
- ISSUE:
  - valid_o=1; decoded fields and pc_o are driven from IR and pc, held stable.
  - On a posedge with ex_ready_i=1: pc<=pc+1, wrapping from 2^ADDR_WIDTH-1 to 0; go FETCH.
  - ex_ready_i=0: stay in ISSUE; outputs held with no change.
- HALT:
  - valid_o=0, imem_req_o=0, halt_o=1.
  - pc_o holds the address of the invalid instruction.
  - Only reset exits HALT.
- Throughput: 2 cycles per instruction minimum (FETCH with same-cycle ack, then ISSUE with ex_ready_i=1). Each cycle of ack delay or ex_ready_i low adds one cycle.
- ex_ready_i is ignored outside ISSUE.
- valid_o never asserts in the same cycle as imem_req_o.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: go HALT, drop imem_req_o, halt_o=1.
  - pc_o holds the unanswered fetch address.
  - An ack in the same cycle the limit is reached wins: the normal fetch completes.
- Undefined: no counter; FETCH waits indefinitely for imem_ack_i.

Test Plan:
- Reset, then same-cycle ack with instr 0x5A53 (ADD, rd=5, rs1=1, rs2=2) and ex_ready_i=1 -> valid_o=1 for one cycle; func_o=5, rd=5, rs1=1, rs2=2, rd_we_o=1, pc_o=0; next fetch address=1.
- Ack delayed 3 cycles, then ex_ready_i held low 4 cycles on STORE 0xC0D0 -> imem_addr_o stable during the wait; valid_o high for 4+1 cycles with func_o=12, rd_we_o=0; PC advances exactly once.
- Fetch returns 0xE000 at pc=7 -> halt_o=1, valid_o=0, imem_req_o=0 permanently; pc_o=7; further acks ignored until reset.
- PC wrap: RESET_PC=2^ADDR_WIDTH-1, ADDI 0x4ABF accepted -> next imem_addr_o=0; imm_o=0x3F.
- Reset asserted mid-FETCH with an ack in the same cycle -> IR not loaded; all outputs at reset values; imem_req_o reasserts at RESET_PC two cycles after release.
- IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> halt_o=1 after 16 FETCH cycles. With ack on cycle 16 -> normal issue, no halt.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end.
// Fetches 16-bit instructions from IMEM over req/ack, holds them in an
// instruction register and presents decoded fields until the execution
// stage accepts them. An invalid opcode (13-15) halts the stage until reset.
// Optional build macro IFETCH_TIMEOUT_EN: halt when a fetch stays unanswered
// for TIMEOUT_CYCLES request cycles.
//
// state | meaning
// FETCH | request IMEM word at pc, wait for ack
// ISSUE | decoded instruction valid, wait for ex_ready_i
// HALT  | invalid opcode (or fetch timeout) seen, wait for reset

package simple_processor_pkg;
    parameter int ADDR_WIDTH = 8;
endpackage

module instr_fetch_decode #(
    parameter int                    ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   imem_ack_i,
    input  logic                   ex_ready_i,
    output logic                   valid_o,
    output logic [3:0]             func_o,
    output logic [2:0]             rd_addr_o,
    output logic [2:0]             rs1_addr_o,
    output logic [2:0]             rs2_addr_o,
    output logic [5:0]             imm_o,
    output logic                   rd_we_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   halt_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [3:0] OP_STORE   = 4'd12;
    localparam logic [3:0] OP_MAX_VAL = 4'd12;

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    // Low for the first cycle after reset so the request starts one cycle late.
    logic                   req_en_q;
    logic                   fetch_timeout;

`ifdef IFETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Count request cycles without ack; cleared whenever we are not fetching.
    always_comb begin
        wait_cnt_d = '0;
        if (imem_req_o && !imem_ack_i) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // The last allowed cycle is reached when TIMEOUT_CYCLES-1 misses are counted;
    // an ack in that cycle still completes the fetch.
    assign fetch_timeout = imem_req_o && !imem_ack_i &&
                           (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter register.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Timeout limit has no effect without the timeout build.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign fetch_timeout  = 1'b0;
`endif

    // Next-state, PC and instruction register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (imem_req_o && imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = (imem_rdata_i[15:12] > OP_MAX_VAL) ? S_HALT : S_ISSUE;
                end else if (fetch_timeout) begin
                    state_d = S_HALT;
                end
            end
            S_ISSUE: begin
                if (ex_ready_i) begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_en_q <= 1'b1;
        end
    end

    // Outputs decoded directly from state, PC and instruction register.
    always_comb begin
        imem_req_o  = (state_q == S_FETCH) && req_en_q;
        imem_addr_o = pc_q;
        valid_o     = (state_q == S_ISSUE);
        halt_o      = (state_q == S_HALT);
        func_o      = ir_q[15:12];
        rd_addr_o   = ir_q[11:9];
        rs1_addr_o  = ir_q[8:6];
        rs2_addr_o  = ir_q[5:3];
        imm_o       = ir_q[5:0];
        rd_we_o     = (state_q == S_ISSUE) && (ir_q[15:12] != OP_STORE);
        pc_o        = pc_q;
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: the IMEM/EX driver pushes the
// expected decode of every accepted instruction; a negedge monitor pops and
// compares whenever the DUT issues an instruction that is accepted.

module tb_instr_fetch_decode;

    localparam int AW = 8;

    logic           clk_i;
    logic           arst_ni;
    logic           imem_req_o;
    logic [AW-1:0]  imem_addr_o;
    logic [15:0]    imem_rdata_i;
    logic           imem_ack_i;
    logic           ex_ready_i;
    logic           valid_o;
    logic [3:0]     func_o;
    logic [2:0]     rd_addr_o;
    logic [2:0]     rs1_addr_o;
    logic [2:0]     rs2_addr_o;
    logic [5:0]     imm_o;
    logic           rd_we_o;
    logic [AW-1:0]  pc_o;
    logic           halt_o;

    instr_fetch_decode #(
        .ADDR_WIDTH    (AW),
        .INSTR_WIDTH   (16),
        .RESET_PC      ('0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .imem_ack_i  (imem_ack_i),
        .ex_ready_i  (ex_ready_i),
        .valid_o     (valid_o),
        .func_o      (func_o),
        .rd_addr_o   (rd_addr_o),
        .rs1_addr_o  (rs1_addr_o),
        .rs2_addr_o  (rs2_addr_o),
        .imm_o       (imm_o),
        .rd_we_o     (rd_we_o),
        .pc_o        (pc_o),
        .halt_o      (halt_o)
    );

    typedef struct {
        int pc;
        int func;
        int rd;
        int rs1;
        int rs2;
        int imm;
        int we;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   model_pc = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: compare at the accept point of every issued instruction.
    always @(negedge clk_i) begin
        if (arst_ni && valid_o) begin
            chk("no_req_with_valid", imem_req_o, 0);
            if (ex_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got func %0d at pc %0d expected nothing", func_o, pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pc_o",   pc_o,       mon_e.pc);
                    chk("func_o", func_o,     mon_e.func);
                    chk("rd",     rd_addr_o,  mon_e.rd);
                    chk("rs1",    rs1_addr_o, mon_e.rs1);
                    chk("rs2",    rs2_addr_o, mon_e.rs2);
                    chk("imm",    imm_o,      mon_e.imm);
                    chk("rd_we",  rd_we_o,    mon_e.we);
                end
            end
        end
    end

    task automatic do_reset();
        arst_ni    = 1'b0;
        imem_ack_i = 1'b0;
        ex_ready_i = 1'b0;
        repeat (2) step();
        exp_q.delete();
        model_pc = 0;
        arst_ni  = 1'b1;
    endtask

    // Serve one fetch with ack_dly idle request cycles, then hold ex_ready_i low
    // for rdy_dly issue cycles before accepting.
    task automatic fetch_one(input logic [15:0] instr, input int ack_dly, input int rdy_dly);
        int   n = 0;
        int   iv;
        int   op;
        exp_t e;
        while (!imem_req_o && n < 50) begin
            step();
            n++;
        end
        chk("req_seen", imem_req_o, 1);
        chk("fetch_addr", imem_addr_o, model_pc);
        chk("valid_low_in_fetch", valid_o, 0);
        for (int i = 0; i < ack_dly; i++) begin
            ex_ready_i = 1'($urandom_range(0, 1));
            step();
            chk("addr_stable", imem_addr_o, model_pc);
            chk("req_held", imem_req_o, 1);
        end
        ex_ready_i   = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = instr;
        iv = int'(instr);
        op = iv / 4096;
        if (op <= 12) begin
            e.pc   = model_pc;
            e.func = op;
            e.rd   = (iv / 512) % 8;
            e.rs1  = (iv / 64) % 8;
            e.rs2  = (iv / 8) % 8;
            e.imm  = iv % 64;
            e.we   = (op == 12) ? 0 : 1;
            exp_q.push_back(e);
        end
        step();
        imem_ack_i   = 1'b0;
        imem_rdata_i = 16'($urandom);
        if (op > 12) return;
        for (int i = 0; i < rdy_dly; i++) begin
            chk("valid_wait", valid_o, 1);
            chk("req_low_in_issue", imem_req_o, 0);
            step();
        end
        chk("valid_accept", valid_o, 1);
        ex_ready_i = 1'b1;
        step();
        ex_ready_i = 1'b0;
        model_pc = (model_pc + 1) % (1 << AW);
        chk("valid_drop", valid_o, 0);
    endtask

    initial begin
        logic [15:0] instr;
        arst_ni      = 1'b0;
        imem_ack_i   = 1'b0;
        ex_ready_i   = 1'b0;
        imem_rdata_i = 16'h0;

        // Reset values, then request delayed by one cycle after release.
        do_reset();
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_halt", halt_o, 0);
        chk("rst_we", rd_we_o, 0);
        chk("rst_func", func_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_pc", pc_o, 0);
        step();
        chk("req_after_release", imem_req_o, 1);

        // ADD with same-cycle ack and immediate accept.
        fetch_one(16'h5A53, 0, 0);
        // STORE with ack delay 3 and ready low 4 cycles.
        fetch_one(16'hC0D0, 3, 4);
        chk("pc_after_store", imem_addr_o, 2);
        for (int i = 2; i < 7; i++) fetch_one(16'h1000 + 16'(i), i % 2, (i + 1) % 3);

        // Invalid opcode at pc 7: sticky halt, acks ignored.
        fetch_one(16'hE000, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("halt_o", halt_o, 1);
            chk("halt_valid", valid_o, 0);
            chk("halt_req", imem_req_o, 0);
            chk("halt_pc", pc_o, 7);
            imem_ack_i   = 1'b1;
            imem_rdata_i = 16'h5A53;
            ex_ready_i   = 1'b1;
            step();
        end
        imem_ack_i = 1'b0;
        ex_ready_i = 1'b0;

        // Reset during a fetch with a coincident ack.
        do_reset();
        step();
        chk("mid_req", imem_req_o, 1);
        arst_ni      = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 16'h5A53;
        step();
        imem_ack_i = 1'b0;
        arst_ni    = 1'b1;
        chk("mid_rst_func", func_o, 0);
        chk("mid_rst_rd", rd_addr_o, 0);
        chk("mid_rst_rs1", rs1_addr_o, 0);
        chk("mid_rst_rs2", rs2_addr_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_req", imem_req_o, 0);
        chk("mid_rst_addr", imem_addr_o, 0);
        step();
        chk("mid_rst_req_back", imem_req_o, 1);
        chk("mid_rst_addr_back", imem_addr_o, 0);

`ifdef IFETCH_TIMEOUT_EN
        // Ack on the last allowed cycle completes normally.
        fetch_one(16'h1234, 15, 0);
        chk("to_no_halt", halt_o, 0);
        while (!imem_req_o) step();
        repeat (15) step();
        chk("to_not_yet", halt_o, 0);
        chk("to_req_still", imem_req_o, 1);
        step();
        chk("to_halt", halt_o, 1);
        chk("to_req_drop", imem_req_o, 0);
        chk("to_valid", valid_o, 0);
        chk("to_pc", pc_o, model_pc);
`else
        // Without the timeout, a long ack delay is simply waited out.
        fetch_one(16'h1234, 20, 0);
        chk("long_wait_no_halt", halt_o, 0);
`endif

        // Random run long enough to wrap the PC; ADDI 0x4ABF placed at the top address.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            instr = 16'($urandom);
            instr[15:12] = 4'($urandom_range(0, 12));
            if (model_pc == (1 << AW) - 1) instr = 16'h4ABF;
            fetch_one(instr, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        fetch_one(16'hF123, 0, 0);
        chk("final_halt", halt_o, 1);
        chk("final_halt_pc", pc_o, model_pc);
        step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
